// File: rtl/data_bus_ctrl.sv
// Data-side bus controller: decodes core loads/stores into a word RAM, an LED
// register, a free-running cycle counter and a valid/ready transmit FIFO.
module data_bus_ctrl #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

  logic [31:0]   r_ram [RAM_WORDS];
  logic [7:0]    r_leds;
  logic [31:0]   r_cnt;
  logic [31:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [2:0]    r_count;
  logic          r_ovf;

  logic [29:0]   w_word;
  logic [5:0]    w_ram_idx;
  logic          w_ram_hit;
  logic          w_sel_led;
  logic          w_sel_cnt;
  logic          w_sel_push;
  logic          w_sel_stat;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_accept;
  logic          w_drop;
  logic [31:0]   w_status;

  // Full 32-bit decode; anything outside the window reads 0 and ignores stores.
  assign w_word     = ALUResult[31:2];
  assign w_ram_idx  = ALUResult[7:2];
  assign w_ram_hit  = (ALUResult[31:8] == 24'h0) && ({26'b0, w_ram_idx} < 32'(RAM_WORDS));
  assign w_sel_led  = (w_word == 30'h400);
  assign w_sel_cnt  = (w_word == 30'h401);
  assign w_sel_push = (w_word == 30'h402);
  assign w_sel_stat = (w_word == 30'h403);

  assign w_empty  = (r_count == 3'd0);
  assign w_full   = (r_count == DEPTH_C);
  assign w_push   = MemWrite && w_sel_push;
  assign w_pop    = tx_valid && tx_ready;
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && !w_accept;
  assign w_status = {26'b0, r_ovf, r_count, w_full, w_empty};

  assign leds     = r_leds;
  assign tx_valid = !w_empty;
  assign tx_data  = w_empty ? 32'h0 : r_fifo[r_rd_ptr];

  always_comb begin
    ReadData = 32'h0;
    if (w_ram_hit)       ReadData = r_ram[w_ram_idx[AW-1:0]];
    else if (w_sel_led)  ReadData = {24'h0, r_leds};
    else if (w_sel_cnt)  ReadData = r_cnt;
    else if (w_sel_stat) ReadData = w_status;
  end

  // Storage arrays carry no reset; emptiness is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (MemWrite && w_ram_hit) r_ram[w_ram_idx[AW-1:0]] <= WriteData;
    if (w_accept)              r_fifo[r_wr_ptr] <= WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_leds <= 8'h0;
      r_cnt  <= 32'h0;
    end else begin
      if (MemWrite && w_sel_led) r_leds <= WriteData[7:0];
      r_cnt <= (MemWrite && w_sel_cnt) ? 32'h0 : r_cnt + 32'h1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= 3'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      // A dropped push wins over a clearing store to the status register.
      if (w_drop)                     r_ovf <= 1'b1;
      else if (MemWrite && w_sel_stat) r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Bench for data_bus_ctrl: directed scenarios plus randomized traffic checked
// against a queue/array reference model of the address map.
module tb_data_bus_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic [7:0]  leds;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_ram [64];
  bit          m_def [64];
  logic [7:0]  m_leds;
  logic [31:0] m_cnt;
  logic [31:0] m_q [$];
  bit          m_ovf;
  logic [31:0] m_popped [$];

  data_bus_ctrl #(.RAM_WORDS(64), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(ReadData), .leds(leds),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_status();
    int n = m_q.size();
    return {26'b0, m_ovf, 3'(n), (n == DEPTH), (n == 0)};
  endfunction

  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    logic [31:0] w = a & 32'hFFFF_FFFC;
    v = 32'h0;
    if (w < 32'h100) begin
      v = m_ram[w[7:2]];
      return m_def[w[7:2]];
    end
    case (w)
      32'h1000: v = {24'h0, m_leds};
      32'h1004: v = m_cnt;
      32'h100C: v = model_status();
      default:  v = 32'h0;
    endcase
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_leds = 8'h0;
    m_cnt  = 32'h0;
    m_q.delete();
    m_ovf  = 1'b0;
  endfunction

  // Apply one bus cycle: check outputs before the edge, then advance the model.
  task automatic drive_cycle(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    logic [31:0] exp_rd;
    logic [31:0] w;
    bit known;
    bit pop;
    MemWrite = we; ALUResult = a; WriteData = wd; tx_ready = rdy;
    #1;
    known = model_read(a, exp_rd);
    if (known) begin
      n_checks++;
      if (ReadData !== exp_rd) begin
        n_fail++;
        $display("FAIL read@%h: got %h expected %h", a, ReadData, exp_rd);
      end
    end
    n_checks++;
    if (tx_valid !== (m_q.size() != 0)) begin
      n_fail++;
      $display("FAIL tx_valid: got %b expected %b", tx_valid, (m_q.size() != 0));
    end
    n_checks++;
    if (tx_data !== ((m_q.size() != 0) ? m_q[0] : 32'h0)) begin
      n_fail++;
      $display("FAIL tx_data: got %h expected %h", tx_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
    end
    n_checks++;
    if (leds !== m_leds) begin
      n_fail++;
      $display("FAIL leds: got %h expected %h", leds, m_leds);
    end
    @(posedge clk);
    w = a & 32'hFFFF_FFFC;
    pop = (m_q.size() != 0) && rdy;
    m_cnt = m_cnt + 32'h1;
    if (we) begin
      if (w < 32'h100) begin
        m_ram[w[7:2]] = wd;
        m_def[w[7:2]] = 1'b1;
      end
      if (w == 32'h1000) m_leds = wd[7:0];
      if (w == 32'h1004) m_cnt = 32'h0;
      if (w == 32'h100C) m_ovf = 1'b0;
    end
    if (we && w == 32'h1008 && m_q.size() == DEPTH && !pop) begin
      m_ovf = 1'b1;
    end else begin
      if (pop) m_popped.push_back(m_q.pop_front());
      if (we && w == 32'h1008) m_q.push_back(wd);
    end
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    MemWrite = 1'b0; tx_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset_tx: got valid=%b data=%h expected valid=0 data=0", tx_valid, tx_data);
    end
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 64; i++) m_def[i] = 1'b0;
    @(posedge clk); #1;
    apply_reset(3);
    n_checks++;
    if (leds !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_leds: got %h expected 00", leds);
    end
    ALUResult = 32'h100C; #1;
    n_checks++;
    if (ReadData !== 32'h1) begin
      n_fail++;
      $display("FAIL reset_status: got %h expected 00000001", ReadData);
    end
  endtask

  task automatic test_counter();
    for (int i = 0; i < 3; i++) begin
      MemWrite = 1'b0; ALUResult = 32'h1004; #1;
      n_checks++;
      if (ReadData !== 32'(i)) begin
        n_fail++;
        $display("FAIL counter_after_reset: got %0d expected %0d", ReadData, i);
      end
      drive_cycle(0, 32'h1004, 0, 0);
    end
    for (int i = 0; i < 100 && m_cnt != 32'd50; i++) drive_cycle(0, 32'h2000, 0, 0);
    drive_cycle(1, 32'h1004, 32'h1234, 0);
    MemWrite = 1'b0; ALUResult = 32'h1004; #1;
    n_checks++;
    if (ReadData !== 32'h0) begin
      n_fail++;
      $display("FAIL counter_clear: got %h expected 0", ReadData);
    end
  endtask

  task automatic test_ram_led();
    drive_cycle(1, 32'h10, 32'hDEADBEEF, 0);
    drive_cycle(1, 32'h1000, 32'hA5, 0);
    MemWrite = 1'b0; ALUResult = 32'h10; #1;
    n_checks++;
    if (ReadData !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL ram_load: got %h expected deadbeef", ReadData);
    end
    ALUResult = 32'h1000; #1;
    n_checks++;
    if (ReadData !== 32'hA5 || leds !== 8'hA5) begin
      n_fail++;
      $display("FAIL led_load: got %h leds=%h expected 000000a5 leds=a5", ReadData, leds);
    end
    ALUResult = 32'h2000; #1;
    n_checks++;
    if (ReadData !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped_load: got %h expected 0", ReadData);
    end
    drive_cycle(0, 32'h10, 0, 0);
  endtask

  task automatic test_fifo_full();
    for (int i = 1; i <= 4; i++) drive_cycle(1, 32'h1008, 32'(i), 0);
    MemWrite = 1'b0; ALUResult = 32'h100C; #1;
    n_checks++;
    if (ReadData !== 32'h12 || tx_data !== 32'h1) begin
      n_fail++;
      $display("FAIL fifo_full_status: got %h head=%h expected 00000012 head=1", ReadData, tx_data);
    end
    drive_cycle(1, 32'h1008, 32'h5, 0);
    MemWrite = 1'b0; ALUResult = 32'h100C; #1;
    n_checks++;
    if (ReadData !== 32'h32 || tx_data !== 32'h1) begin
      n_fail++;
      $display("FAIL fifo_overflow: got %h head=%h expected 00000032 head=1", ReadData, tx_data);
    end
    drive_cycle(1, 32'h100C, 32'hFFFF_FFFF, 0);
    MemWrite = 1'b0; ALUResult = 32'h100C; #1;
    n_checks++;
    if (ReadData !== 32'h12) begin
      n_fail++;
      $display("FAIL ovf_clear: got %h expected 00000012", ReadData);
    end
    drive_cycle(1, 32'h1008, 32'h6, 1);
    MemWrite = 1'b0; ALUResult = 32'h100C; tx_ready = 1'b0; #1;
    n_checks++;
    if (ReadData !== 32'h12 || tx_data !== 32'h2) begin
      n_fail++;
      $display("FAIL full_push_pop: got %h head=%h expected 00000012 head=2", ReadData, tx_data);
    end
  endtask

  task automatic test_drain();
    logic [31:0] exp_seq [4] = '{32'h2, 32'h3, 32'h4, 32'h6};
    m_popped.delete();
    for (int i = 0; i < 10 && tx_valid; i++) drive_cycle(0, 32'h100C, 0, 1);
    n_checks++;
    if (m_popped.size() != 4) begin
      n_fail++;
      $display("FAIL drain_count: got %0d expected 4", m_popped.size());
    end
    for (int i = 0; i < 4 && i < m_popped.size(); i++) begin
      n_checks++;
      if (m_popped[i] !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got %h expected %h", i, m_popped[i], exp_seq[i]);
      end
    end
    MemWrite = 1'b0; ALUResult = 32'h100C; #1;
    n_checks++;
    if (ReadData !== 32'h1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drained_status: got %h valid=%b expected 00000001 valid=0", ReadData, tx_valid);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 32'h1008, 32'h77, 0);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 32'h77) begin
      n_fail++;
      $display("FAIL push_before_reset: got valid=%b data=%h expected valid=1 data=77", tx_valid, tx_data);
    end
    apply_reset(2);
    MemWrite = 1'b0; ALUResult = 32'h100C; #1;
    n_checks++;
    if (ReadData !== 32'h1) begin
      n_fail++;
      $display("FAIL status_after_reset: got %h expected 00000001", ReadData);
    end
  endtask

  task automatic test_back_to_back();
    m_popped.delete();
    for (int v = 10; v <= 20; v++) begin
      MemWrite = 1'b0; ALUResult = 32'h100C; #1;
      n_checks++;
      if (ReadData[4:2] > 3'd1 || ReadData[5] !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_status: got %h expected count<=1 and no overflow", ReadData);
      end
      drive_cycle(1, 32'h1008, 32'(v), 1);
    end
    for (int i = 0; i < 5 && tx_valid; i++) drive_cycle(0, 32'h0, 0, 1);
    n_checks++;
    if (m_popped.size() != 11) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 11", m_popped.size());
    end
    for (int i = 0; i < m_popped.size(); i++) begin
      n_checks++;
      if (m_popped[i] !== 32'(10 + i)) begin
        n_fail++;
        $display("FAIL b2b_order[%0d]: got %h expected %h", i, m_popped[i], 32'(10 + i));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      case ($urandom_range(0, 7))
        0: a = {24'h0, r[7:0]};
        1: a = 32'h1000 | {30'h0, r[1:0]};
        2: a = 32'h1004;
        3: a = 32'h1008;
        4: a = 32'h100C;
        5: a = 32'h2000;
        6: a = 32'h8000_1000;
        default: a = 32'h0000_0104;
      endcase
      drive_cycle(($urandom_range(0, 9) < 4), a, $urandom, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_ram_led();
    test_fifo_full();
    test_drain();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
